// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param_if
//  Description : Handshake/data bundle for sync_fifo_param. The producer and
//                consumer side (master) drives the requests and data; the
//                FIFO (slave) returns the read data, status and error flags.
//  Signals     : wr_en, din, rd_en, clr_err        master -> slave
//                dout, dout_valid, full, empty,
//                almost_full, almost_empty, count,
//                overflow, underflow                slave -> master
//  Revision    : 1.0  initial release
// ============================================================================
interface sync_fifo_param_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic          clr_err;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport master (
        output wr_en, din, rd_en, clr_err,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clr_err,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Parametrised single-clock FIFO with same-cycle read+write,
//                occupancy count, programmable almost-full/almost-empty
//                thresholds and sticky overflow/underflow error flags.
//                Read data is registered (one cycle latency) and qualified by
//                a single-cycle dout_valid pulse per accepted read.
//  Ports       : clk    - clock, all logic on posedge
//                reset  - synchronous, active-high; dominates all inputs
//                bus    - sync_fifo_param_if slave modport (requests, data,
//                         status and error flags)
//  Parameters  : DW, DEPTH (power of two, >=2), AF_THRESH (1..DEPTH),
//                AE_THRESH (0..AF_THRESH-1)
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DW        = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    sync_fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    // Thresholds pre-sized to the count width so every compare is width-matched.
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_THRESH);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------------
    generate
        if (DW < 1) begin : g_bad_dw
            $fatal(1, "sync_fifo_param: DW must be >= 1");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "sync_fifo_param: DEPTH must be a power of two >= 2");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $fatal(1, "sync_fifo_param: AF_THRESH must be in 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH) begin : g_bad_ae
            $fatal(1, "sync_fifo_param: AE_THRESH must be in 0..AF_THRESH-1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------------
    // Pointers carry one extra wrap bit so that full (difference == DEPTH)
    // and empty (difference == 0) are distinguishable.
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   occ;
    logic          is_full;
    logic          is_empty;
    logic          wr_acc;
    logic          rd_acc;
    logic [DW-1:0] dout_q;
    logic          dout_valid_q;
    logic          overflow_q;
    logic          underflow_q;

    assign occ      = wptr - rptr;
    assign is_full  = (occ == FULL_CNT);
    assign is_empty = (occ == '0);

    // Acceptance uses the status seen at the start of the cycle, so a read
    // into an empty FIFO is rejected even if a write lands the same cycle
    // (no bypass), and a write into a full FIFO is rejected even if a read
    // frees a slot the same cycle.
    assign wr_acc = bus.wr_en && !is_full;
    assign rd_acc = bus.rd_en && !is_empty;

    // Memory has no reset; contents survive a reset. Writes are blocked
    // while reset is asserted so reset fully dominates the cycle.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wptr[AW-1:0]] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr   <= rptr + 1'b1;
                dout_q <= mem[rptr[AW-1:0]];
            end
            dout_valid_q <= rd_acc;

            // A new error event in the same cycle as clr_err keeps the flag set.
            if (bus.wr_en && is_full) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end

            if (bus.rd_en && is_empty) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.dout         = dout_q;
    assign bus.dout_valid   = dout_valid_q;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (occ >= AF_CNT);
    assign bus.almost_empty = (occ <= AE_CNT);
    assign bus.count        = occ;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
`default_nettype wire
